bcd_seq_conv: RTL

BCD_SEQ_CONV -- requirements
Module: bcd_seq_conv

---
 rtl/bcd_seq_conv_pkg.sv | 8 +
 rtl/bcd_seq_conv_add3.sv | 9 +
 rtl/bcd_seq_conv.sv | 67 ++++++
 3 files changed

// File: rtl/bcd_seq_conv_pkg.sv
// bcd_seq_conv_pkg: shared FSM state enum and width/iteration constants for the BCD converter
package bcd_seq_conv_pkg;
  localparam int DATA_W  = 8;
  localparam int ITER_N  = 8;
  localparam int DIGIT_W = 4;
  localparam int SR_W    = 3 * DIGIT_W + DATA_W;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
endpackage

// File: rtl/bcd_seq_conv_add3.sv
// bcd_add3: double-dabble nibble correction (add 3 when >= 5); ports i_nib in, o_nib out
module bcd_add3
  import bcd_seq_conv_pkg::*;
(
  input  logic [DIGIT_W-1:0] i_nib,
  output logic [DIGIT_W-1:0] o_nib
);
  assign o_nib = (i_nib >= DIGIT_W'(5)) ? i_nib + DIGIT_W'(3) : i_nib;
endmodule

// File: rtl/bcd_seq_conv.sv
// bcd_seq_conv: sequential 8-bit binary to 3-digit BCD converter (double dabble, 9-cycle latency); ports clk, rst_n (async low), start/num in, busy/done/sign/hundreds/tens/ones out; define BCD_SIGNED_EN for two's-complement input with sign output
module bcd_seq_conv
  import bcd_seq_conv_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [DATA_W-1:0]  num,
  output logic               busy,
  output logic               done,
  output logic               sign,
  output logic [DIGIT_W-1:0] hundreds,
  output logic [DIGIT_W-1:0] tens,
  output logic [DIGIT_W-1:0] ones
);
  state_t            r_state, w_next;
  logic [SR_W-1:0]   r_sr, w_adj, w_shift;
  logic [2:0]        r_cnt;
  logic              r_neg, w_neg, w_last;
  logic [DATA_W-1:0] w_mag;
`ifdef BCD_SIGNED_EN
  assign w_neg = num[DATA_W-1];
  // 8-bit negation leaves 0x80 as 0x80, which read unsigned is 128
  assign w_mag = w_neg ? DATA_W'(-num) : num;
`else
  assign w_neg = 1'b0;
  assign w_mag = num;
`endif
  assign w_adj[DATA_W-1:0] = r_sr[DATA_W-1:0];
  for (genvar d = 0; d < 3; d++) begin : g_add
    bcd_add3 u_add3 (
      .i_nib(r_sr[DATA_W + DIGIT_W*d +: DIGIT_W]),
      .o_nib(w_adj[DATA_W + DIGIT_W*d +: DIGIT_W])
    );
  end
  assign w_shift = {w_adj[SR_W-2:0], 1'b0};
  assign w_last  = r_cnt == 3'(ITER_N - 1);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end
  always_comb begin
    w_next = (r_state == IDLE)  ? (start  ? SHIFT : IDLE) :
             (r_state == SHIFT) ? (w_last ? DONE  : SHIFT) : IDLE;
    busy   = r_state != IDLE;
    done   = r_state == DONE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sr     <= '0;
      r_cnt    <= '0;
      r_neg    <= 1'b0;
      sign     <= 1'b0;
      hundreds <= '0;
      tens     <= '0;
      ones     <= '0;
    end else if (r_state == IDLE && start) begin
      r_sr  <= {{(3*DIGIT_W){1'b0}}, w_mag};
      r_cnt <= '0;
      r_neg <= w_neg;
    end else if (r_state == SHIFT) begin
      r_sr  <= w_shift;
      r_cnt <= r_cnt + 3'd1;
      if (w_last) {sign, hundreds, tens, ones} <= {r_neg, w_shift[SR_W-1:DATA_W]};
    end
  end
endmodule
